mul_seq_k: RTL and testbench
============================

Name: mul_seq_K

Overview:
- Iterative shift-add 12x12 multiplier. Directly upstream of the Kyber Barrett reducer.
- Takes two coefficients in [0,4095] and produces the full 24-bit unreduced product. product_o connects directly to the reducer's 24-bit product input.
- Valid/ready handshake on both sides. One multiplication in flight at a time, fixed latency.

Parameters:
- W, 12, operand width. Product width is 2*W. Must be even when RADIX4_MUL_K_EN is defined.

Ports:
- clk_i  input  1  clock, rising edge
- rst_i  input  1  synchronous, active-high reset
- a_i  input  W  multiplicand
- b_i  input  W  multiplier
- valid_i  input  1  operands valid
- ready_o  output  1  block can accept operands
- product_o  output  2W  a*b, unreduced
- valid_o  output  1  product_o valid
- ready_i  input  1  downstream accepts product

Behaviour:
- Reset (rst_i=1 at a rising edge):
  - state=IDLE.
  - ready_o=0 during reset, 1 in first cycle after.
  - valid_o=0, product_o=0, internal accumulator/counter=0.
  - Reset mid-operation aborts the operation; the partial product is discarded.
- States: IDLE, BUSY, DONE.
  - ready_o = (state==IDLE). valid_o = (state==DONE). Both driven from state registers, no combinational path from valid_i/ready_i.
- IDLE:
  - Edge with valid_i&ready_o: latch mcand={W zeros,a_i}, mplier=b_i, acc=0, cnt=0; go BUSY.
  - a_i/b_i ignored on every other edge.
- BUSY, one step per edge:
  - if mplier[0], acc+=mcand.
  - mcand<<=1, mplier>>=1, cnt+=1.
  - On the step where cnt==W-1 before increment: go DONE, product_o<=final acc.
- Latency: accepting edge = E0. Steps occur at edges E1..EW (W=12 -> E12). valid_o=1 from the cycle after EW.
- Arithmetic:
  - acc is 2W bits. No overflow is possible: max 4095*4095=16769025 < 2^24.
  - No range check: values 3329..4095 are multiplied as plain unsigned.
- DONE:
  - product_o and valid_o held stable while ready_i=0, for any number of cycles.
  - Edge with ready_i=1: go IDLE. valid_o drops next cycle; product_o keeps its last value until the next DONE.
- No bypass: ready_o does not rise in the same cycle as the output handshake.
  - Back-to-back throughput with ready_i=1 and valid_i=1: one accept every W+2 edges (14 for W=12).
- Fixed latency regardless of operand values; no early termination on zero operands.

Optional Feature:
- Macro: RADIX4_MUL_K_EN.
- Defined: each BUSY step consumes mplier[1:0].
  - acc += mcand*{0,1,2,3}. The 3x term is formed as mcand + (mcand<<1), no multiplier primitive.
  - Then mcand<<=2, mplier>>=2.
  - W/2 steps (6 for W=12); valid_o from the cycle after E(W/2); throughput one per W/2+2 edges (8).
- Undefined: radix-2 behaviour above, W steps.
- Port list, handshake rules and product values are identical in both builds.

Test Plan:
- Reset, then a_i=3328, b_i=3328, valid_i=1, ready_i=1 -> ready_o=0 after E0; valid_o=1 exactly 12 edges after acceptance (6 with RADIX4_MUL_K_EN); product_o=11075584 (0xA90000).
- a_i=4095, b_i=4095 -> product_o=16769025 (0xFFE001). a_i=0, b_i=4095 -> product_o=0, same latency.
- Backpressure: ready_i=0 for 5 cycles after valid_o rises, while a_i/b_i/valid_i toggle -> product_o and valid_o stable, ready_o=0; ready_i=1 -> IDLE next edge, ready_o=1 the cycle after.
- Throughput: valid_i and ready_i held 1, three operand pairs (1,1), (17,3329), (2048,2) -> products 1, 56593, 4096; accepts spaced 14 edges apart (8 with RADIX4_MUL_K_EN).
- Reset mid-op: rst_i=1 for one edge at BUSY step 5 -> next cycle IDLE, ready_o=1, valid_o=0, product_o=0; a following 5*7 returns 35 with normal latency.
- Ignored inputs: valid_i=1 with a_i changing every cycle during BUSY -> result equals the operands latched at E0.

Source files
------------

// File: rtl/mul_seq_k.sv
// Iterative shift-add W x W unsigned multiplier with valid/ready on both sides.
// Define RADIX4_MUL_K_EN to retire two multiplier bits per step (W must be even).
module mul_seq_k #(
    parameter int W = 12
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [W-1:0]     a_i,
    input  logic [W-1:0]     b_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic [2*W-1:0]   product_o,
    output logic             valid_o,
    input  logic             ready_i
);

`ifdef RADIX4_MUL_K_EN
    localparam int STEPS   = W / 2;
    localparam int STEP_SH = 2;
`else
    localparam int STEPS   = W;
    localparam int STEP_SH = 1;
`endif
    localparam int CNT_W = $clog2(STEPS + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [2*W-1:0]   mcand;
    logic [W-1:0]     mplier;
    logic [2*W-1:0]   acc;
    logic [2*W-1:0]   acc_nxt;
    logic [CNT_W-1:0] cnt;
    logic             last_step;

`ifdef RADIX4_MUL_K_EN
    // Partial product for one radix-4 digit; 3x built from an add, no multiplier.
    function automatic logic [2*W-1:0] digit_term(input logic [2*W-1:0] m,
                                                   input logic [1:0]     d);
        case (d)
            2'd0:    digit_term = '0;
            2'd1:    digit_term = m;
            2'd2:    digit_term = m << 1;
            default: digit_term = m + (m << 1);
        endcase
    endfunction

    assign acc_nxt = acc + digit_term(mcand, mplier[1:0]);
`else
    assign acc_nxt = acc + (mplier[0] ? mcand : '0);
`endif

    assign last_step = (cnt == CNT_W'(STEPS - 1));

    // ready_o is also held low while reset is asserted.
    assign ready_o = (state == IDLE) && !rst_i;
    assign valid_o = (state == DONE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (valid_i)   state_nxt = BUSY;
            BUSY:    if (last_step) state_nxt = DONE;
            DONE:    if (ready_i)   state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // Datapath: latch on accept, one shift-add step per edge while BUSY.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            cnt       <= '0;
            product_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid_i) begin
                        mcand  <= {{W{1'b0}}, a_i};
                        mplier <= b_i;
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                BUSY: begin
                    acc    <= acc_nxt;
                    mcand  <= mcand << STEP_SH;
                    mplier <= mplier >> STEP_SH;
                    cnt    <= cnt + 1'b1;
                    if (last_step) begin
                        product_o <= acc_nxt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_seq_k.sv
// Directed-vector bench for mul_seq_k: latency, backpressure, throughput, reset abort.
module tb_mul_seq_k;

    localparam int W = 12;
`ifdef RADIX4_MUL_K_EN
    localparam int STEPS = W / 2;
`else
    localparam int STEPS = W;
`endif

    logic           clk = 1'b0;
    logic           rst_i;
    logic [W-1:0]   a_i;
    logic [W-1:0]   b_i;
    logic           valid_i;
    logic           ready_o;
    logic [2*W-1:0] product_o;
    logic           valid_o;
    logic           ready_i;

    int cyc   = 0;
    int n_vec = 0;
    int n_err = 0;

    mul_seq_k #(.W(W)) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .a_i       (a_i),
        .b_i       (b_i),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .product_o (product_o),
        .valid_o   (valid_o),
        .ready_i   (ready_i)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!ready_o && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_ready"}, 32'(ready_o), 32'd1);
    endtask

    // Scrambles operands every cycle while busy; the DUT must ignore them.
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!valid_o && lat < 40) begin
            a_i = W'($urandom);
            b_i = W'($urandom);
            tick();
            lat++;
        end
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [31:0] exp, input string tag);
        int lat;
        ready_i = 1'b1;
        wait_ready(tag);
        a_i = a;
        b_i = b;
        valid_i = 1'b1;
        tick();
        check({tag, "_rdy_busy"}, 32'(ready_o), 32'd0);
        wait_valid(lat);
        check({tag, "_latency"}, 32'(lat), 32'(STEPS));
        check({tag, "_product"}, 32'(product_o), exp);
        valid_i = 1'b0;
        tick();
        check({tag, "_vld_drop"}, 32'(valid_o), 32'd0);
        check({tag, "_rdy_back"}, 32'(ready_o), 32'd1);
    endtask

    logic [W-1:0] pa [3] = '{12'd1, 12'd17, 12'd2048};
    logic [W-1:0] pb [3] = '{12'd1, 12'd3329, 12'd2};
    logic [31:0]  pp [3] = '{32'd1, 32'd56593, 32'd4096};

    initial begin
        int lat;
        int acc_at [3];

        rst_i   = 1'b1;
        a_i     = '0;
        b_i     = '0;
        valid_i = 1'b0;
        ready_i = 1'b1;
        tick();
        tick();
        check("rst_ready", 32'(ready_o), 32'd0);
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_product", 32'(product_o), 32'd0);
        rst_i = 1'b0;
        #1;
        check("post_rst_ready", 32'(ready_o), 32'd1);

        run_op(12'd3328, 12'd3328, 32'd11075584, "q_sq");
        run_op(12'd4095, 12'd4095, 32'd16769025, "max_sq");
        run_op(12'd0, 12'd4095, 32'd0, "zero_a");

        // Backpressure: hold the result for five cycles with noisy inputs.
        ready_i = 1'b0;
        wait_ready("bp");
        a_i = 12'd100;
        b_i = 12'd200;
        valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        wait_valid(lat);
        check("bp_latency", 32'(lat), 32'(STEPS));
        for (int i = 0; i < 5; i++) begin
            a_i = W'($urandom);
            b_i = W'($urandom);
            valid_i = i[0];
            tick();
            check("bp_hold_valid", 32'(valid_o), 32'd1);
            check("bp_hold_product", 32'(product_o), 32'd20000);
            check("bp_hold_ready", 32'(ready_o), 32'd0);
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        tick();
        check("bp_release_valid", 32'(valid_o), 32'd0);
        check("bp_release_ready", 32'(ready_o), 32'd1);
        check("bp_product_kept", 32'(product_o), 32'd20000);

        // Throughput with valid_i and ready_i held high.
        ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a_i = pa[i];
            b_i = pb[i];
            valid_i = 1'b1;
            wait_ready("tp");
            tick();
            acc_at[i] = cyc;
            wait_valid(lat);
            check("tp_latency", 32'(lat), 32'(STEPS));
            check("tp_product", 32'(product_o), pp[i]);
        end
        valid_i = 1'b0;
        check("tp_spacing_1", 32'(acc_at[1] - acc_at[0]), 32'(STEPS + 2));
        check("tp_spacing_2", 32'(acc_at[2] - acc_at[1]), 32'(STEPS + 2));
        tick();
        tick();

        // Reset in the middle of a multiplication.
        wait_ready("rst_mid");
        a_i = 12'd7;
        b_i = 12'd9;
        valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        repeat (5) tick();
        check("rst_mid_busy", 32'(ready_o), 32'd0);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        #1;
        check("rst_mid_ready", 32'(ready_o), 32'd1);
        check("rst_mid_valid", 32'(valid_o), 32'd0);
        check("rst_mid_product", 32'(product_o), 32'd0);
        run_op(12'd5, 12'd7, 32'd35, "after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
